// File: rtl/space_wire_stat_counter_bank.sv
// SpaceWire statistics counter bank: per-channel event counters with wrap/saturate,
// sticky overflow, atomic snapshot into shadow registers and a two-stage registered read port.
module space_wire_stat_counter_bank #(
  parameter int NUM_CH   = 8,
  parameter int CNT_W    = 32,
  parameter int SATURATE = 0,
  parameter int SNAP_CLR = 0,
  parameter int AW       = 5
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_clear,
  input  logic [NUM_CH-1:0] i_inc,
  input  logic              i_snapshot,
  input  logic              i_rd_en,
  input  logic [AW-1:0]     i_rd_addr,
  output logic [CNT_W-1:0]  o_rd_data,
  output logic              o_rd_ovf,
  output logic              o_rd_valid,
  output logic [NUM_CH-1:0] o_ovf,
  output logic [NUM_CH-1:0] o_inc_mon
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [CNT_W-1:0]  r_live      [NUM_CH];
  logic [CNT_W-1:0]  r_shadow    [NUM_CH];
  logic [NUM_CH-1:0] r_ovf;
  logic [NUM_CH-1:0] r_shadow_ovf;
  logic [NUM_CH-1:0] r_inc_mon;

  logic [CNT_W-1:0]  w_live_nxt  [NUM_CH];
  logic [NUM_CH-1:0] w_ovf_nxt;

  logic [CNT_W-1:0]  w_rd_sel_data;
  logic              w_rd_sel_ovf;

  logic [CNT_W-1:0]  r_rd_p1_data;
  logic              r_rd_p1_ovf;
  logic              r_rd_p1_valid;
  logic [CNT_W-1:0]  r_rd_data;
  logic              r_rd_ovf;
  logic              r_rd_valid;

  // Next live count and overflow per channel: clear > snapshot-restart > increment > hold.
  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      w_live_nxt[ch] = r_live[ch];
      w_ovf_nxt[ch]  = r_ovf[ch];
      if (i_clear) begin
        w_live_nxt[ch] = CNT_ZERO;
        w_ovf_nxt[ch]  = 1'b0;
      end else if (i_snapshot && (SNAP_CLR != 0)) begin
        // The snapshot-cycle event belongs to the new interval, so none is lost.
        w_live_nxt[ch] = i_inc[ch] ? CNT_ONE : CNT_ZERO;
        w_ovf_nxt[ch]  = 1'b0;
      end else if (i_inc[ch]) begin
        if (r_live[ch] == CNT_MAX) begin
          w_live_nxt[ch] = (SATURATE != 0) ? CNT_MAX : CNT_ZERO;
          w_ovf_nxt[ch]  = 1'b1;
        end else begin
          w_live_nxt[ch] = r_live[ch] + CNT_ONE;
          w_ovf_nxt[ch]  = r_ovf[ch];
        end
      end else begin
        w_live_nxt[ch] = r_live[ch];
        w_ovf_nxt[ch]  = r_ovf[ch];
      end
    end
  end

  // Live counters, sticky overflow flags and the increment activity monitor.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        r_live[ch] <= CNT_ZERO;
      end
      r_ovf     <= {NUM_CH{1'b0}};
      r_inc_mon <= {NUM_CH{1'b0}};
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        r_live[ch] <= w_live_nxt[ch];
      end
      r_ovf     <= w_ovf_nxt;
      r_inc_mon <= i_inc;
    end
  end

  // Shadow registers capture the pre-update live state of every channel on one edge.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        r_shadow[ch] <= CNT_ZERO;
      end
      r_shadow_ovf <= {NUM_CH{1'b0}};
    end else if (i_clear) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        r_shadow[ch] <= CNT_ZERO;
      end
      r_shadow_ovf <= {NUM_CH{1'b0}};
    end else if (i_snapshot) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        r_shadow[ch] <= r_live[ch];
      end
      r_shadow_ovf <= r_ovf;
    end else begin
      r_shadow_ovf <= r_shadow_ovf;
    end
  end

  // Read mux; addresses beyond the populated channels return zero.
  always_comb begin
    w_rd_sel_data = CNT_ZERO;
    w_rd_sel_ovf  = 1'b0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (i_rd_addr == AW'(ch)) begin
        w_rd_sel_data = r_shadow[ch];
        w_rd_sel_ovf  = r_shadow_ovf[ch];
      end else begin
        w_rd_sel_data = w_rd_sel_data;
        w_rd_sel_ovf  = w_rd_sel_ovf;
      end
    end
  end

  // Two-stage read pipeline; output data holds its last value between reads.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rd_p1_data  <= CNT_ZERO;
      r_rd_p1_ovf   <= 1'b0;
      r_rd_p1_valid <= 1'b0;
      r_rd_data     <= CNT_ZERO;
      r_rd_ovf      <= 1'b0;
      r_rd_valid    <= 1'b0;
    end else begin
      r_rd_p1_valid <= i_rd_en;
      r_rd_valid    <= r_rd_p1_valid;
      if (i_rd_en) begin
        r_rd_p1_data <= w_rd_sel_data;
        r_rd_p1_ovf  <= w_rd_sel_ovf;
      end else begin
        r_rd_p1_data <= r_rd_p1_data;
        r_rd_p1_ovf  <= r_rd_p1_ovf;
      end
      if (r_rd_p1_valid) begin
        r_rd_data <= r_rd_p1_data;
        r_rd_ovf  <= r_rd_p1_ovf;
      end else begin
        r_rd_data <= r_rd_data;
        r_rd_ovf  <= r_rd_ovf;
      end
    end
  end

  assign o_rd_data  = r_rd_data;
  assign o_rd_ovf   = r_rd_ovf;
  assign o_rd_valid = r_rd_valid;
  assign o_ovf      = r_ovf;
  assign o_inc_mon  = r_inc_mon;

endmodule

// File: tb/tb_space_wire_stat_counter_bank.sv
// Directed bench for space_wire_stat_counter_bank: three instances share stimulus
// (wrap, saturate, snapshot-clear) so every mode is checked against hand-computed values.
module tb_space_wire_stat_counter_bank;

  localparam int NUM_CH = 8;
  localparam int CNT_W  = 8;
  localparam int AW     = 4;

  logic              clk;
  logic              rst_n;
  logic              i_clear;
  logic [NUM_CH-1:0] i_inc;
  logic              i_snapshot;
  logic              i_rd_en;
  logic [AW-1:0]     i_rd_addr;

  logic [CNT_W-1:0]  a_rd_data, s_rd_data, c_rd_data;
  logic              a_rd_ovf, s_rd_ovf, c_rd_ovf;
  logic              a_rd_valid, s_rd_valid, c_rd_valid;
  logic [NUM_CH-1:0] a_ovf, s_ovf, c_ovf;
  logic [NUM_CH-1:0] a_inc_mon, s_inc_mon, c_inc_mon;

  int checks;
  int failures;

  space_wire_stat_counter_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .SATURATE(0), .SNAP_CLR(0), .AW(AW)) dut_a (
    .i_clk(clk), .i_reset_n(rst_n), .i_clear(i_clear), .i_inc(i_inc), .i_snapshot(i_snapshot),
    .i_rd_en(i_rd_en), .i_rd_addr(i_rd_addr), .o_rd_data(a_rd_data), .o_rd_ovf(a_rd_ovf),
    .o_rd_valid(a_rd_valid), .o_ovf(a_ovf), .o_inc_mon(a_inc_mon));

  space_wire_stat_counter_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .SATURATE(1), .SNAP_CLR(0), .AW(AW)) dut_s (
    .i_clk(clk), .i_reset_n(rst_n), .i_clear(i_clear), .i_inc(i_inc), .i_snapshot(i_snapshot),
    .i_rd_en(i_rd_en), .i_rd_addr(i_rd_addr), .o_rd_data(s_rd_data), .o_rd_ovf(s_rd_ovf),
    .o_rd_valid(s_rd_valid), .o_ovf(s_ovf), .o_inc_mon(s_inc_mon));

  space_wire_stat_counter_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .SATURATE(0), .SNAP_CLR(1), .AW(AW)) dut_c (
    .i_clk(clk), .i_reset_n(rst_n), .i_clear(i_clear), .i_inc(i_inc), .i_snapshot(i_snapshot),
    .i_rd_en(i_rd_en), .i_rd_addr(i_rd_addr), .o_rd_data(c_rd_data), .o_rd_ovf(c_rd_ovf),
    .o_rd_valid(c_rd_valid), .o_ovf(c_ovf), .o_inc_mon(c_inc_mon));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int ch, input int n);
    i_inc = '0;
    i_inc[ch] = 1'b1;
    repeat (n) tick();
    i_inc = '0;
  endtask

  task automatic snap();
    i_snapshot = 1'b1;
    tick();
    i_snapshot = 1'b0;
  endtask

  task automatic clr();
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
  endtask

  // Issues one read and returns just after the edge at which o_rd_valid rises.
  task automatic rd(input logic [AW-1:0] addr);
    i_rd_en = 1'b1;
    i_rd_addr = addr;
    tick();
    i_rd_en = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    checks++; if (a_rd_valid !== 1'b0 || a_rd_data !== 8'd0 || a_ovf !== 8'h00 || a_inc_mon !== 8'h00) begin failures++; $display("FAIL reset_init got valid=%0b data=%0d ovf=%0h mon=%0h exp all 0", a_rd_valid, a_rd_data, a_ovf, a_inc_mon); end
    pulse(0, 5);
    snap();
    i_inc = 8'h01;
    i_rd_en = 1'b1;
    i_rd_addr = 4'd0;
    tick();
    i_rd_en = 1'b0;
    tick();
    checks++; if (a_rd_valid !== 1'b1 || a_rd_data !== 8'd5 || a_inc_mon !== 8'h01) begin failures++; $display("FAIL reset_pre got valid=%0b data=%0d mon=%0h exp 1 5 01", a_rd_valid, a_rd_data, a_inc_mon); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (a_rd_valid !== 1'b0 || a_rd_data !== 8'd0 || a_rd_ovf !== 1'b0 || a_inc_mon !== 8'h00 || s_inc_mon !== 8'h00 || c_inc_mon !== 8'h00) begin failures++; $display("FAIL reset_async got valid=%0b data=%0d ovf=%0b mon=%0h exp all 0", a_rd_valid, a_rd_data, a_rd_ovf, a_inc_mon); end
    i_inc = '0;
    #2 rst_n = 1'b1;
    tick();
    snap();
    rd(4'd0);
    checks++; if (a_rd_valid !== 1'b1 || a_rd_data !== 8'd0) begin failures++; $display("FAIL reset_live got valid=%0b data=%0d exp 1 0", a_rd_valid, a_rd_data); end
  endtask

  task automatic test_count_read();
    clr();
    pulse(2, 3);
    pulse(5, 7);
    snap();
    i_rd_en = 1'b1;
    i_rd_addr = 4'd2;
    tick();
    i_rd_en = 1'b0;
    checks++; if (a_rd_valid !== 1'b0) begin failures++; $display("FAIL rd_latency got valid=%0b exp 0", a_rd_valid); end
    tick();
    checks++; if (a_rd_valid !== 1'b1 || a_rd_data !== 8'd3 || a_rd_ovf !== 1'b0) begin failures++; $display("FAIL rd_ch2 got valid=%0b data=%0d ovf=%0b exp 1 3 0", a_rd_valid, a_rd_data, a_rd_ovf); end
    tick();
    checks++; if (a_rd_valid !== 1'b0 || a_rd_data !== 8'd3) begin failures++; $display("FAIL rd_hold got valid=%0b data=%0d exp 0 3", a_rd_valid, a_rd_data); end
    rd(4'd5);
    checks++; if (a_rd_valid !== 1'b1 || a_rd_data !== 8'd7) begin failures++; $display("FAIL rd_ch5 got valid=%0b data=%0d exp 1 7", a_rd_valid, a_rd_data); end
  endtask

  task automatic test_wrap_saturate();
    clr();
    pulse(1, 255);
    checks++; if (a_ovf !== 8'h00 || s_ovf !== 8'h00) begin failures++; $display("FAIL ovf_at_max got wrap=%0h sat=%0h exp 00 00", a_ovf, s_ovf); end
    pulse(1, 2);
    checks++; if (a_ovf !== 8'h02 || s_ovf !== 8'h02 || c_ovf !== 8'h02) begin failures++; $display("FAIL ovf_set got wrap=%0h sat=%0h sclr=%0h exp 02", a_ovf, s_ovf, c_ovf); end
    snap();
    checks++; if (a_ovf !== 8'h02 || c_ovf !== 8'h00) begin failures++; $display("FAIL ovf_after_snap got wrap=%0h sclr=%0h exp 02 00", a_ovf, c_ovf); end
    rd(4'd1);
    checks++; if (a_rd_data !== 8'd1 || a_rd_ovf !== 1'b1) begin failures++; $display("FAIL wrap_val got data=%0d ovf=%0b exp 1 1", a_rd_data, a_rd_ovf); end
    checks++; if (s_rd_data !== 8'd255 || s_rd_ovf !== 1'b1) begin failures++; $display("FAIL sat_val got data=%0d ovf=%0b exp 255 1", s_rd_data, s_rd_ovf); end
    checks++; if (c_rd_data !== 8'd1 || c_rd_ovf !== 1'b1) begin failures++; $display("FAIL sclr_shadow got data=%0d ovf=%0b exp 1 1", c_rd_data, c_rd_ovf); end
  endtask

  task automatic test_snap_clr();
    clr();
    pulse(3, 10);
    i_inc = 8'h08;
    i_snapshot = 1'b1;
    tick();
    i_snapshot = 1'b0;
    tick();
    tick();
    i_inc = '0;
    rd(4'd3);
    checks++; if (c_rd_data !== 8'd10 || a_rd_data !== 8'd10) begin failures++; $display("FAIL snapclr_first got sclr=%0d plain=%0d exp 10 10", c_rd_data, a_rd_data); end
    snap();
    rd(4'd3);
    checks++; if (c_rd_data !== 8'd3 || a_rd_data !== 8'd13) begin failures++; $display("FAIL snapclr_second got sclr=%0d plain=%0d exp 3 13", c_rd_data, a_rd_data); end
  endtask

  task automatic test_collisions();
    clr();
    pulse(4, 2);
    i_clear = 1'b1;
    i_inc = 8'h10;
    tick();
    i_clear = 1'b0;
    i_inc = '0;
    snap();
    rd(4'd4);
    checks++; if (a_rd_data !== 8'd0) begin failures++; $display("FAIL clear_inc got data=%0d exp 0", a_rd_data); end
    pulse(4, 4);
    i_snapshot = 1'b1;
    i_inc = 8'h10;
    tick();
    i_snapshot = 1'b0;
    i_inc = '0;
    rd(4'd4);
    checks++; if (a_rd_data !== 8'd4) begin failures++; $display("FAIL snap_inc_shadow got data=%0d exp 4", a_rd_data); end
    i_snapshot = 1'b1;
    i_rd_en = 1'b1;
    i_rd_addr = 4'd4;
    tick();
    i_snapshot = 1'b0;
    i_rd_en = 1'b0;
    tick();
    checks++; if (a_rd_valid !== 1'b1 || a_rd_data !== 8'd4) begin failures++; $display("FAIL rd_vs_snap got valid=%0b data=%0d exp 1 4", a_rd_valid, a_rd_data); end
    rd(4'd4);
    checks++; if (a_rd_data !== 8'd5) begin failures++; $display("FAIL snap_inc_live got data=%0d exp 5", a_rd_data); end
    pulse(4, 1);
    i_clear = 1'b1;
    i_snapshot = 1'b1;
    i_inc = 8'hA5;
    tick();
    i_clear = 1'b0;
    i_snapshot = 1'b0;
    i_inc = '0;
    checks++; if (a_inc_mon !== 8'hA5 || c_inc_mon !== 8'hA5) begin failures++; $display("FAIL inc_mon got %0h exp a5", a_inc_mon); end
    checks++; if (a_ovf !== 8'h00) begin failures++; $display("FAIL clr_snap_ovf got %0h exp 00", a_ovf); end
    rd(4'd4);
    checks++; if (a_rd_data !== 8'd0 || a_inc_mon !== 8'h00) begin failures++; $display("FAIL clr_snap_shadow got data=%0d mon=%0h exp 0 00", a_rd_data, a_inc_mon); end
  endtask

  task automatic test_back_to_back();
    clr();
    pulse(2, 1);
    pulse(5, 2);
    snap();
    i_rd_en = 1'b1;
    i_rd_addr = 4'd8;
    tick();
    i_rd_addr = 4'd2;
    tick();
    checks++; if (a_rd_valid !== 1'b1 || a_rd_data !== 8'd0 || a_rd_ovf !== 1'b0) begin failures++; $display("FAIL b2b_addr8 got valid=%0b data=%0d ovf=%0b exp 1 0 0", a_rd_valid, a_rd_data, a_rd_ovf); end
    i_rd_addr = 4'd5;
    tick();
    i_rd_en = 1'b0;
    checks++; if (a_rd_valid !== 1'b1 || a_rd_data !== 8'd1) begin failures++; $display("FAIL b2b_ch2 got valid=%0b data=%0d exp 1 1", a_rd_valid, a_rd_data); end
    tick();
    checks++; if (a_rd_valid !== 1'b1 || a_rd_data !== 8'd2) begin failures++; $display("FAIL b2b_ch5 got valid=%0b data=%0d exp 1 2", a_rd_valid, a_rd_data); end
    tick();
    checks++; if (a_rd_valid !== 1'b0 || a_rd_data !== 8'd2) begin failures++; $display("FAIL b2b_end got valid=%0b data=%0d exp 0 2", a_rd_valid, a_rd_data); end
    rd(4'd15);
    checks++; if (a_rd_valid !== 1'b1 || a_rd_data !== 8'd0 || a_rd_ovf !== 1'b0) begin failures++; $display("FAIL rd_addr15 got valid=%0b data=%0d ovf=%0b exp 1 0 0", a_rd_valid, a_rd_data, a_rd_ovf); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    i_clear = 1'b0;
    i_inc = '0;
    i_snapshot = 1'b0;
    i_rd_en = 1'b0;
    i_rd_addr = '0;
    #23 rst_n = 1'b1;
    tick();
    test_reset();
    test_count_read();
    test_wrap_saturate();
    test_snap_clr();
    test_collisions();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
